// File: rtl/lsu_dport.sv
// lsu_dport: load/store unit, the CPU-side initiator of the data-memory port.
//
// Accepts one load or store at a time over a valid/ready request channel.
// Drives a word address, lane-replicated write data and per-byte write enables
// towards a memory whose reads are combinational and whose writes take effect
// on the clock edge. Loads are lane-selected and sign/zero extended, and the
// result is returned on a valid/ready response channel.
//
// Parameters:
//   RESP_HOLD  1: rsp_valid holds until rsp_ready; 0: one-cycle pulse, rsp_ready ignored.
//
// Optional feature (compile-time macro LSU_MISALIGN_SPLIT_EN):
//   When defined, misaligned H/W requests are split into two aligned accesses
//   (word A, then word A+1). When undefined, they return rsp_err with no access.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    extended load data (0 for stores/errors), error flag
//   daddr, dwdata, dwe    memory word address, write data, byte write enables
//   drdata                combinational read data for word daddr[31:2]
module lsu_dport #(
  parameter int unsigned RESP_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;       // word part of the address lives in daddr_q
  logic [31:0] wdata_q;
  logic        split_q;
  logic [31:0] lo_q;        // first word of a split load
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] daddr_q;
  logic [31:0] dwdata_q;
  logic [3:0]  dwe_q;

  // Byte lanes touched by an access of the given size starting at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = {24'b0, raw[7:0]};
      3'b101:  extend = {16'b0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Request decode.
  logic        req_legal;
  logic        req_misal;
  logic [3:0]  req_lo_mask;
  logic [31:0] req_lo_data;
  logic [31:0] req_repl;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = ~req_we;
      default:                req_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = |req_addr[1:0];
      default: req_misal = 1'b0;
    endcase
    req_lo_mask = size_mask(req_funct3[1:0]) << req_addr[1:0];
    req_lo_data = req_wdata << {req_addr[1:0], 3'b000};
    case (req_funct3[1:0])
      2'b00:   req_repl = {4{req_wdata[7:0]}};
      2'b01:   req_repl = {2{req_wdata[15:0]}};
      default: req_repl = req_wdata;
    endcase
  end

  // Second half of a split store: the lanes that spilled past lane 3.
  logic [2:0]  hi_mask_sh;
  logic [5:0]  hi_data_sh;
  logic [3:0]  q_hi_mask;
  logic [31:0] q_hi_data;

  always_comb begin
    hi_mask_sh = 3'd4 - {1'b0, off_q};
    hi_data_sh = 6'd32 - {1'b0, off_q, 3'b000};
    q_hi_mask  = size_mask(funct3_q[1:0]) >> hi_mask_sh;
    q_hi_data  = wdata_q >> hi_data_sh;
  end

  // Load lane selection; a split load joins the saved first word with drdata.
  logic [31:0] load_raw;

  always_comb begin
    load_raw = drdata;
    if (split_q) begin
      case (off_q)
        2'd1:    load_raw = {drdata[7:0],  lo_q[31:8]};
        2'd2:    load_raw = {drdata[15:0], lo_q[31:16]};
        2'd3:    load_raw = {drdata[23:0], lo_q[31:24]};
        default: load_raw = lo_q;
      endcase
    end else begin
      case (off_q)
        2'd1:    load_raw = {8'b0,  drdata[31:8]};
        2'd2:    load_raw = {16'b0, drdata[31:16]};
        2'd3:    load_raw = {24'b0, drdata[31:24]};
        default: load_raw = drdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      dwe_q       <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            split_q     <= req_misal & SplitEn;
            rsp_rdata_q <= '0;
            if (!req_legal || (req_misal && !SplitEn)) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q   <= StAcc0;
              rsp_err_q <= 1'b0;
              daddr_q   <= {req_addr[31:2], 2'b00};
              dwe_q     <= req_we ? req_lo_mask : 4'b0000;
              // Split stores need true lane positions; aligned ones replicate.
              dwdata_q  <= req_misal ? req_lo_data : req_repl;
            end
          end
        end
        StAcc0: begin
          dwe_q <= 4'b0000;
          if (split_q) begin
            state_q  <= StAcc1;
            lo_q     <= drdata;
            daddr_q  <= daddr_q + 32'd4;
            dwe_q    <= we_q ? q_hi_mask : 4'b0000;
            dwdata_q <= q_hi_data;
          end else begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            if (!we_q) rsp_rdata_q <= extend(funct3_q, load_raw);
          end
        end
        StAcc1: begin
          dwe_q       <= 4'b0000;
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          if (!we_q) rsp_rdata_q <= extend(funct3_q, load_raw);
        end
        StResp: begin
          if (RESP_HOLD == 0 || rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  // Gated by reset so a store interrupted by reset never writes in that cycle.
  assign dwe       = dwe_q & {4{rst_n}};

endmodule

// File: tb/tb_lsu_dport.sv
module tb_lsu_dport;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata, daddr, dwdata, drdata;
  logic [3:0]  dwe;

  lsu_dport #(.RESP_HOLD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .dwe        (dwe),
    .drdata     (drdata)
  );

  // 4 KiB data memory (addresses alias modulo 4096) plus a byte-level reference copy.
  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h8899AABB;
    if (i == 32'h41) return 32'h44332211;
    if (i == 32'h80) return 32'h00000000;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  logic [31:0] mem [1024];
  logic [7:0]  ref_mem [4096];
  bit          mem_loaded = 1'b0;

  assign drdata = mem[daddr[11:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      for (int n = 0; n < 4; n++)
        if (dwe[n]) mem[daddr[11:2]][8*n +: 8] <= dwdata[8*n +: 8];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, size/alignment rules, arithmetic extension.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int writes);
    int n;
    bit legal, mis;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = (addr % n) != 0;
    err = 1'b0; rdata = '0; lat = 2; writes = 0;
    if (!legal || (mis && !SplitEn)) begin
      err = 1'b1;
      lat = 1;
      return;
    end
    if (mis) lat = 3;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[(addr + 32'(i)) & 32'hFFF] = 8'(wdata >> (8 * i));
      writes = (int'(addr % 4) + n - 1) / 4 + 1;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(addr + 32'(i)) & 32'hFFF]) << (8 * i));
      if (!f3[2] && n < 4 && v >= 32'(1 << (8 * n - 1))) v = v - 32'(1 << (8 * n));
      rdata = v;
    end
  endtask

  // Issues one request from a negedge, waits (bounded) for the response, holds
  // rsp_ready low for `delay` response cycles, then completes the handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic exp_err,
                        input logic [31:0] exp_rdata, input int exp_lat, input int exp_writes,
                        output logic [3:0] dwe1, output logic [31:0] daddr1,
                        output logic [31:0] dwdata1);
    int lat, writes;
    bit seen;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    dwe1 = dwe; daddr1 = daddr; dwdata1 = dwdata;
    lat = 0; writes = 0; seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (dwe != 4'b0000) writes++;
      if (rsp_valid) begin
        lat = c;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("write_cycles", 32'(writes), 32'(exp_writes));
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_dwe", {28'b0, dwe}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } vec_t;

  vec_t        tbl [14];
  logic        m_err;
  logic [31:0] m_rdata, a_daddr, a_dwdata, old_word;
  int          m_lat, m_writes, sel, dl;
  logic [3:0]  a_dwe;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  f3_list [5];
  int          mem_bad;

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(init_word(i) >> (8 * b));
    f3_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    //           we    f3      addr        wdata          err   rdata          lat dwe      daddr       dwdata
    tbl[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,          1'b0, 32'hFFFFFFAA, 2, 4'b0000, 32'h0,   32'h0};
    tbl[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,          1'b0, 32'h00000088, 2, 4'b0000, 32'h0,   32'h0};
`ifdef LSU_MISALIGN_SPLIT_EN
    tbl[2]  = '{1'b0, 3'b010, 32'h102, 32'h0,          1'b0, 32'h22118899, 3, 4'b0000, 32'h0,   32'h0};
`else
    tbl[2]  = '{1'b0, 3'b010, 32'h102, 32'h0,          1'b1, 32'h00000000, 1, 4'b0000, 32'h0,   32'h0};
`endif
    tbl[3]  = '{1'b1, 3'b001, 32'h102, 32'h00001234,   1'b0, 32'h0,        2, 4'b1100, 32'h100, 32'h12341234};
    tbl[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,          1'b0, 32'h1234AABB, 2, 4'b0000, 32'h0,   32'h0};
    tbl[5]  = '{1'b0, 3'b001, 32'h100, 32'h0,          1'b0, 32'hFFFFAABB, 2, 4'b0000, 32'h0,   32'h0};
    tbl[6]  = '{1'b0, 3'b101, 32'h102, 32'h0,          1'b0, 32'h00001234, 2, 4'b0000, 32'h0,   32'h0};
    tbl[7]  = '{1'b0, 3'b011, 32'h100, 32'h0,          1'b1, 32'h0,        1, 4'b0000, 32'h0,   32'h0};
    tbl[8]  = '{1'b1, 3'b100, 32'h100, 32'hFFFFFFFF,   1'b1, 32'h0,        1, 4'b0000, 32'h0,   32'h0};
    tbl[9]  = '{1'b1, 3'b000, 32'h203, 32'hABCDEF7F,   1'b0, 32'h0,        2, 4'b1000, 32'h200, 32'h7F7F7F7F};
    tbl[10] = '{1'b0, 3'b000, 32'h203, 32'h0,          1'b0, 32'h0000007F, 2, 4'b0000, 32'h0,   32'h0};
    tbl[11] = '{1'b0, 3'b010, 32'h200, 32'h0,          1'b0, 32'h7F000000, 2, 4'b0000, 32'h0,   32'h0};
    tbl[12] = '{1'b1, 3'b010, 32'h104, 32'hCAFEF00D,   1'b0, 32'h0,        2, 4'b1111, 32'h104, 32'hCAFEF00D};
    tbl[13] = '{1'b0, 3'b001, 32'h106, 32'h0,          1'b0, 32'hFFFFCAFE, 2, 4'b0000, 32'h0,   32'h0};

    for (int k = 0; k < 14; k++) begin
      model(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wdata, m_err, m_rdata, m_lat, m_writes);
      do_req(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wdata, 0, tbl[k].err, tbl[k].rdata,
             tbl[k].lat, m_writes, a_dwe, a_daddr, a_dwdata);
      check("acc_dwe", {28'b0, a_dwe}, {28'b0, tbl[k].dwe});
      if (tbl[k].dwe != 4'b0000) begin
        check("acc_daddr", a_daddr, tbl[k].daddr);
        check("acc_dwdata", a_dwdata, tbl[k].dwdata);
      end
    end

    // Response held with rsp_ready low for five cycles.
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 5, 1'b0, 32'h1234AABB, 2, 0, a_dwe, a_daddr, a_dwdata);

    // Reset asserted during the access cycle of a word store.
    old_word = {ref_mem[32'h203], ref_mem[32'h202], ref_mem[32'h201], ref_mem[32'h200]};
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstacc_dwe_live", {28'b0, dwe}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("rstacc_dwe_gated", {28'b0, dwe}, 32'd0);
    @(negedge clk);
    check_reset_vals();
    check("rstacc_mem", mem[32'h80], old_word);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      r_we = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      r_f3 = (sel < 8) ? f3_list[sel % 5] : 3'($urandom);
      r_addr = $urandom & 32'hFFF;
      if ($urandom_range(0, 3) != 0) begin
        if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        else if (r_f3[1:0] != 2'b00) r_addr[1:0] = 2'b00;
      end
      r_wdata = $urandom;
      dl = int'($urandom_range(0, 2));
      model(r_we, r_f3, r_addr, r_wdata, m_err, m_rdata, m_lat, m_writes);
      do_req(r_we, r_f3, r_addr, r_wdata, dl, m_err, m_rdata, m_lat, m_writes,
             a_dwe, a_daddr, a_dwdata);
    end

    mem_bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) mem_bad++;
    check("final_mem_words_bad", 32'(mem_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
